seq_detector_param: RTL and testbench

Parametrised serial bit-pattern detector: accepts one bit per qualified clock and flags each occurrence of a programmable PAT_LEN-bit pattern. Overlapping or non-overlapping detection is selectable at run time, and a saturating match counter is provided. It generalises the fixed single-pattern sequence-detector FSMs and drops into any serial-input datapath in the FSM library.

---
 rtl/seq_det_pkg.sv | 26 ++
 rtl/seq_detector_param_sat_counter.sv | 23 ++
 rtl/seq_detector_param.sv | 88 ++++++++
 tb/tb_seq_detector_param.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
package seq_det_pkg;

   localparam int unsigned PAT_LEN_MAX = 16;
   localparam int unsigned CNT_W_MAX   = 32;

   // Detection mode as seen by the completing bit.
   typedef enum logic {
      DET_NOVL = 1'b0,
      DET_OVL  = 1'b1
   } det_mode_e;

   // Width needed to hold a fill level of 0..pat_len.
   function automatic int unsigned fill_w(input int unsigned pat_len);
      return $clog2(pat_len + 1);
   endfunction

   function automatic bit pat_len_ok(input int unsigned pat_len);
      return (pat_len >= 2) && (pat_len <= PAT_LEN_MAX);
   endfunction

   function automatic bit cnt_w_ok(input int unsigned cnt_w);
      return (cnt_w >= 1) && (cnt_w <= CNT_W_MAX);
   endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   // Count register: clear wins, otherwise increment until all ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with programmable pattern, run-time
// overlapping/non-overlapping mode and a saturating match counter.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int unsigned          PAT_LEN = 5,
   parameter logic [PAT_LEN-1:0]   PATTERN = 5'b10001,
   parameter int unsigned          CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               in,
   input  logic               ovl,
   input  logic               pat_ld,
   input  logic [PAT_LEN-1:0] pat,
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt
);

   if (!pat_len_ok(PAT_LEN)) begin : g_bad_pat_len
      $error("seq_detector_param: PAT_LEN=%0d outside 2..%0d", PAT_LEN, PAT_LEN_MAX);
   end
   if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
      $error("seq_detector_param: CNT_W=%0d outside 1..%0d", CNT_W, CNT_W_MAX);
   end

   localparam int unsigned      FW        = fill_w(PAT_LEN);
   localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_LEN);
   localparam logic [FW-1:0]    FILL_NEAR = FW'(PAT_LEN - 1);

   // The oldest history bit is never compared again once shifted, so only
   // PAT_LEN-1 bits are stored; the candidate word re-forms the full window.
   logic [PAT_LEN-2:0] hist;
   logic [PAT_LEN-1:0] pat_q;
   logic [PAT_LEN-1:0] cand;
   logic [FW-1:0]      fill;
   logic [FW-1:0]      fill_nxt;
   logic               accept;
   logic               hit;
   det_mode_e          mode;

   // Candidate window, hit decision and next fill level for an accepted bit.
   always_comb begin
      accept   = en & ~pat_ld;
      cand     = {hist, in};
      mode     = det_mode_e'(ovl);
      hit      = accept && (fill >= FILL_NEAR) && (cand == pat_q);
      fill_nxt = fill;
      if (hit) begin
         fill_nxt = (mode == DET_OVL) ? FILL_FULL : '0;
      end else if (fill != FILL_FULL) begin
         fill_nxt = fill + 1'b1;
      end
   end

   // Detector state: pattern load discards the bit, otherwise shift on en.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist  <= '0;
         fill  <= '0;
         pat_q <= PATTERN;
         match <= 1'b0;
      end else if (pat_ld) begin
         pat_q <= pat;
         fill  <= '0;
         match <= 1'b0;
      end else if (en) begin
         hist  <= cand[PAT_LEN-2:0];
         fill  <= fill_nxt;
         match <= hit;
      end else begin
         match <= 1'b0;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk (clk),
      .rst (rst),
      .inc (hit),
      .clr (cnt_clr),
      .q   (match_cnt)
   );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param with a queue-based scoreboard
// fed by an independent reference model of the accepted bit stream.
module tb_seq_detector_param;

   localparam int unsigned PL   = 5;
   localparam int unsigned CW   = 4;
   localparam logic [PL-1:0] PATV = 5'b10001;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          in;
   logic          ovl;
   logic          pat_ld;
   logic [PL-1:0] pat;
   logic          cnt_clr;
   logic          match;
   logic [CW-1:0] match_cnt;

   always #5 clk = ~clk;

   seq_detector_param #(
      .PAT_LEN (PL),
      .PATTERN (PATV),
      .CNT_W   (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in        (in),
      .ovl       (ovl),
      .pat_ld    (pat_ld),
      .pat       (pat),
      .cnt_clr   (cnt_clr),
      .match     (match),
      .match_cnt (match_cnt)
   );

   typedef struct {
      logic          m;
      logic [CW-1:0] c;
   } exp_t;

   exp_t          sb[$];
   int            errors = 0;
   int            checks = 0;
   int            npulse = 0;

   // Reference model: accepted bits since the last restart point.
   bit            mq[$];
   int            run;
   logic [PL-1:0] mpat;
   int            mcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      run  = 0;
      mpat = PATV;
      mcnt = 0;
   endtask

   // One clock of stimulus: predict, push, clock, pop and compare.
   task automatic cyc(input logic e, input logic i, input logic o, input logic ld,
                      input logic [PL-1:0] p, input logic clr, input string tag);
      exp_t          x;
      logic          hit;
      logic [PL-1:0] win;
      en = e; in = i; ovl = o; pat_ld = ld; pat = p; cnt_clr = clr;
      hit = 1'b0;
      if (ld) begin
         mpat = p;
         run  = 0;
      end else if (e) begin
         mq.push_back(i);
         if (mq.size() > PL) void'(mq.pop_front());
         run++;
         if (run >= PL) begin
            win = '0;
            foreach (mq[k]) win = {win[PL-2:0], logic'(mq[k])};
            if (win == mpat) begin
               hit = 1'b1;
               if (!o) run = 0;
            end
         end
      end
      if (clr) mcnt = 0;
      else if (hit && mcnt < 15) mcnt++;
      x.m = hit;
      x.c = CW'(mcnt);
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed=empty-scoreboard expected=entry", tag);
      end else begin
         x = sb.pop_front();
         chk({tag, ".match"}, 32'(match), 32'(x.m));
         chk({tag, ".cnt"}, 32'(match_cnt), 32'(x.c));
      end
      if (match === 1'b1) npulse++;
   endtask

   // Feed n accepted bits of v, MSB first.
   task automatic feed(input logic [31:0] v, input int n, input logic o, input string tag);
      for (int k = n - 1; k >= 0; k--) cyc(1'b1, v[k], o, 1'b0, '0, 1'b0, tag);
   endtask

   // Restore the default pattern and clear the counter.
   task automatic reinit(input logic [PL-1:0] p);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, p, 1'b1, "reinit");
      npulse = 0;
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; in = 1'b0; ovl = 1'b0;
      pat_ld = 1'b0; pat = '0; cnt_clr = 1'b0;
      model_reset();
      #2;
      chk("reset.match", 32'(match), 32'd0);
      chk("reset.cnt", 32'(match_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Idle cycles with en=0 must not disturb anything.
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'(k), 1'b0, 1'b0, '0, 1'b0, "idle");

      // Non-overlapping: 1,0,0,0,1,0,0,0,1 -> one match.
      feed(32'b100010001, 9, 1'b0, "novl");
      chk("novl.total", 32'(match_cnt), 32'd1);
      chk("novl.pulses", 32'(npulse), 32'd1);

      // Overlapping: same stream -> two matches.
      reinit(PATV);
      feed(32'b100010001, 9, 1'b1, "ovl");
      chk("ovl.total", 32'(match_cnt), 32'd2);
      chk("ovl.pulses", 32'(npulse), 32'd2);

      // Gapped: 1,0, three idle cycles, 0,0,1.
      reinit(PATV);
      feed(32'b10, 2, 1'b0, "gap.a");
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'($urandom), 1'b0, 1'b0, '0, 1'b0, "gap.idle");
      feed(32'b001, 3, 1'b0, "gap.b");
      chk("gap.total", 32'(match_cnt), 32'd1);
      chk("gap.pulses", 32'(npulse), 32'd1);

      // Pattern reload discards the concurrent bit; old pattern never fires.
      reinit(PATV);
      feed(32'b1000, 4, 1'b0, "reload.a");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 5'b11011, 1'b0, "reload.ld");
      feed(32'b11011, 5, 1'b0, "reload.b");
      chk("reload.total", 32'(match_cnt), 32'd1);
      chk("reload.pulses", 32'(npulse), 32'd1);

      // Mid-stream asynchronous reset restores the default pattern.
      npulse = 0;
      feed(32'b1000, 4, 1'b0, "rstmid.a");
      en = 1'b0;
      rst = 1'b0;
      #1;
      chk("rstmid.async.match", 32'(match), 32'd0);
      chk("rstmid.async.cnt", 32'(match_cnt), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, "rstmid.b");
      chk("rstmid.pulses", 32'(npulse), 32'd0);
      feed(32'b0001, 4, 1'b0, "rstmid.c");

      // Saturation: prefix 1,0,0,0 then 0,0,0,1 seventeen times.
      reinit(PATV);
      feed(32'b1000, 4, 1'b1, "sat.pre");
      for (int r = 0; r < 17; r++) feed(32'b0001, 4, 1'b1, "sat");
      chk("sat.total", 32'(match_cnt), 32'd15);
      chk("sat.pulses", 32'(npulse), 32'd16);

      // Clear on the same edge as a hit: match pulses, counter reads zero.
      feed(32'b000, 3, 1'b1, "clrhit.a");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, "clrhit");
      chk("clrhit.match", 32'(match), 32'd1);
      chk("clrhit.cnt", 32'(match_cnt), 32'd0);
      feed(32'b0001, 4, 1'b0, "clrhit.b");
      chk("clrhit.after", 32'(match_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
